// File: rtl/if_fetch_stage.sv
// -----------------------------------------------------------------------------
// if_fetch_stage
//
// Instruction-fetch stage sitting between the next-PC selector and the ID
// stage. It owns the fetch PC, issues one instruction-memory request at a
// time, drops wrong-path responses after a control transfer, buffers a
// response that lands while ID is stalled, and drives the IF/ID register.
//
// Parameters
//   RESET_PC      PC value loaded on reset
//
// Ports
//   clk           clock; all state updates on the rising edge
//   rst_n         synchronous active-low reset
//   pc_in         next PC from the next-PC selector (pc_f+4 or a target)
//   redirect      control transfer taken this cycle; pc_in is the target
//   stall_f       hazard stall: hold IF/ID outputs, issue no new request
//   pc_f          current fetch PC
//   imem_req      memory request valid
//   imem_addr     request address (always equal to pc_f)
//   imem_ready    memory accepts the request this cycle
//   imem_rvalid   response valid, at least one cycle after acceptance
//   imem_rdata    response instruction word
//   inst_d        instruction to ID
//   pc_d          PC of inst_d
//   inst_valid_d  inst_d/pc_d valid (0 = bubble)
// -----------------------------------------------------------------------------
module if_fetch_stage #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] pc_in,
   input  logic        redirect,
   input  logic        stall_f,
   output logic [31:0] pc_f,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ready,
   input  logic        imem_rvalid,
   input  logic [31:0] imem_rdata,
   output logic [31:0] inst_d,
   output logic [31:0] pc_d,
   output logic        inst_valid_d
);

   // S_REQ  : ready to issue a request for pc_f
   // S_WAIT : request accepted, waiting for its response
   // S_DROP : request accepted but made stale by a redirect; eat its response
   // S_HOLD : response captured in the hold buffer while ID was stalled
   typedef enum logic [1:0] {
      S_REQ  = 2'd0,
      S_WAIT = 2'd1,
      S_DROP = 2'd2,
      S_HOLD = 2'd3
   } state_t;

   state_t      state_q, state_d;

   logic [31:0] pc_f_q,         pc_f_d;
   logic [31:0] req_pc_q,       req_pc_d;
   logic [31:0] buf_q,          buf_d;
   logic [31:0] inst_d_q,       inst_d_d;
   logic [31:0] pc_d_q,         pc_d_d;
   logic        inst_valid_d_q, inst_valid_d_d;

   // Decoded per-cycle actions from the output process.
   logic        accept;
   logic        deliver;
   logic        capture;
   logic [31:0] deliver_inst;

   // ---------------------------------------------------------------------------
   // FSM state register
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= S_REQ;
      end else begin
         state_q <= state_d;
      end
   end

   // ---------------------------------------------------------------------------
   // FSM next-state logic. redirect wins over stall_f in every state.
   // ---------------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_REQ: begin
            if (!redirect && accept) begin
               state_d = S_WAIT;
            end
         end
         S_WAIT: begin
            if (redirect) begin
               // A response in the same cycle as the redirect is simply thrown
               // away; otherwise the stale response is still on its way.
               state_d = imem_rvalid ? S_REQ : S_DROP;
            end else if (imem_rvalid) begin
               state_d = stall_f ? S_HOLD : S_REQ;
            end
         end
         S_DROP: begin
            // A further redirect only updates pc_f; the stale response is
            // still the one event that frees the memory port.
            if (imem_rvalid) begin
               state_d = S_REQ;
            end
         end
         S_HOLD: begin
            if (redirect || !stall_f) begin
               state_d = S_REQ;
            end
         end
         default: begin
            state_d = S_REQ;
         end
      endcase
   end

   // ---------------------------------------------------------------------------
   // FSM output logic
   // ---------------------------------------------------------------------------
   always_comb begin
      imem_req     = 1'b0;
      deliver      = 1'b0;
      capture      = 1'b0;
      deliver_inst = imem_rdata;
      case (state_q)
         S_REQ: begin
            imem_req = !stall_f && !redirect;
         end
         S_WAIT: begin
            deliver      = imem_rvalid && !redirect && !stall_f;
            capture      = imem_rvalid && !redirect &&  stall_f;
            deliver_inst = imem_rdata;
         end
         S_DROP: begin
            deliver = 1'b0;
         end
         S_HOLD: begin
            deliver      = !redirect && !stall_f;
            deliver_inst = buf_q;
         end
         default: begin
            imem_req = 1'b0;
         end
      endcase
   end

   assign accept = imem_req && imem_ready;

   // ---------------------------------------------------------------------------
   // PC, request-PC and hold-buffer next values
   // ---------------------------------------------------------------------------
   always_comb begin
      pc_f_d   = pc_f_q;
      req_pc_d = req_pc_q;
      buf_d    = buf_q;

      // pc_f only moves on an accepted request or a redirect; both take pc_in.
      if (redirect || accept) begin
         pc_f_d = pc_in;
      end

      // Remember which PC the outstanding request belongs to.
      if (accept) begin
         req_pc_d = pc_f_q;
      end

      if (capture) begin
         buf_d = imem_rdata;
      end else if (state_q == S_HOLD && redirect) begin
         buf_d = 32'h0000_0000;
      end
   end

   // ---------------------------------------------------------------------------
   // IF/ID register next values: flush, then hold, then load, else bubble
   // ---------------------------------------------------------------------------
   always_comb begin
      inst_d_d       = inst_d_q;
      pc_d_d         = pc_d_q;
      inst_valid_d_d = 1'b0;

      if (redirect) begin
         inst_valid_d_d = 1'b0;
      end else if (stall_f) begin
         inst_valid_d_d = inst_valid_d_q;
      end else if (deliver) begin
         inst_d_d       = deliver_inst;
         pc_d_d         = req_pc_q;
         inst_valid_d_d = 1'b1;
      end
   end

   // ---------------------------------------------------------------------------
   // Datapath registers
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         pc_f_q         <= RESET_PC;
         req_pc_q       <= 32'h0000_0000;
         buf_q          <= 32'h0000_0000;
         inst_d_q       <= 32'h0000_0000;
         pc_d_q         <= 32'h0000_0000;
         inst_valid_d_q <= 1'b0;
      end else begin
         pc_f_q         <= pc_f_d;
         req_pc_q       <= req_pc_d;
         buf_q          <= buf_d;
         inst_d_q       <= inst_d_d;
         pc_d_q         <= pc_d_d;
         inst_valid_d_q <= inst_valid_d_d;
      end
   end

   assign pc_f         = pc_f_q;
   assign imem_addr    = pc_f_q;
   assign inst_d       = inst_d_q;
   assign pc_d         = pc_d_q;
   assign inst_valid_d = inst_valid_d_q;

endmodule

// File: tb/tb_if_fetch_stage.sv
// -----------------------------------------------------------------------------
// tb_if_fetch_stage
//
// Directed bench for if_fetch_stage. Inputs change 1 ns after a rising edge;
// outputs are sampled 1 ns after that, well away from the active edge.
// -----------------------------------------------------------------------------
module tb_if_fetch_stage;

   logic        clk;
   logic        rst_n;
   logic [31:0] pc_in;
   logic        redirect;
   logic        stall_f;
   logic [31:0] pc_f;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ready;
   logic        imem_rvalid;
   logic [31:0] imem_rdata;
   logic [31:0] inst_d;
   logic [31:0] pc_d;
   logic        inst_valid_d;

   int tests_run    = 0;
   int tests_failed = 0;

   if_fetch_stage #(.RESET_PC(32'h0000_0000)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .pc_in        (pc_in),
      .redirect     (redirect),
      .stall_f      (stall_f),
      .pc_f         (pc_f),
      .imem_req     (imem_req),
      .imem_addr    (imem_addr),
      .imem_ready   (imem_ready),
      .imem_rvalid  (imem_rvalid),
      .imem_rdata   (imem_rdata),
      .inst_d       (inst_d),
      .pc_d         (pc_d),
      .inst_valid_d (inst_valid_d)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance to 1 ns after the next rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Let combinational outputs settle after an input change.
   task automatic settle();
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; pc_in = 32'h0; redirect = 1'b0; stall_f = 1'b0;
      imem_ready = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'h0;
      tick(); tick();
      settle();
      tests_run++;
      if (pc_f !== 32'h0) begin
         tests_failed++; $display("FAIL reset_pc_f got=%h exp=%h", pc_f, 32'h0);
      end
      tests_run++;
      if (inst_valid_d !== 1'b0 || inst_d !== 32'h0 || pc_d !== 32'h0) begin
         tests_failed++;
         $display("FAIL reset_ifid got v=%b i=%h p=%h exp v=0 i=0 p=0", inst_valid_d, inst_d, pc_d);
      end
   endtask

   // Release reset; three back-to-back fetches with rvalid one cycle after accept.
   task automatic test_sequential();
      logic [31:0] addrs [3];
      logic [31:0] datas [3];
      addrs = '{32'h0, 32'h4, 32'h8};
      datas = '{32'hA0, 32'hA4, 32'hA8};
      rst_n = 1'b1; imem_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         pc_in = addrs[i] + 32'h4;
         settle();
         tests_run++;
         if (imem_req !== 1'b1 || imem_addr !== addrs[i]) begin
            tests_failed++;
            $display("FAIL seq_req[%0d] got req=%b addr=%h exp req=1 addr=%h", i, imem_req, imem_addr, addrs[i]);
         end
         tick();
         tests_run++;
         if (pc_f !== addrs[i] + 32'h4 || inst_valid_d !== 1'b0) begin
            tests_failed++;
            $display("FAIL seq_accept[%0d] got pc_f=%h v=%b exp pc_f=%h v=0", i, pc_f, inst_valid_d, addrs[i] + 32'h4);
         end
         imem_rvalid = 1'b1; imem_rdata = datas[i];
         tick();
         imem_rvalid = 1'b0;
         settle();
         tests_run++;
         if (inst_valid_d !== 1'b1 || inst_d !== datas[i] || pc_d !== addrs[i]) begin
            tests_failed++;
            $display("FAIL seq_deliver[%0d] got v=%b i=%h p=%h exp v=1 i=%h p=%h", i, inst_valid_d, inst_d, pc_d, datas[i], addrs[i]);
         end
      end
   endtask

   // Response arrives during a 3-cycle stall; delivered exactly once afterwards.
   task automatic test_stall();
      pc_in = 32'h10;
      tick();                       // accept 0xC
      imem_rvalid = 1'b1; imem_rdata = 32'hAC; stall_f = 1'b1;
      tick();                       // captured into hold buffer
      imem_rvalid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         settle();
         tests_run++;
         if (imem_req !== 1'b0 || inst_d !== 32'hA8 || pc_d !== 32'h8 || inst_valid_d !== 1'b0) begin
            tests_failed++;
            $display("FAIL stall_hold[%0d] got req=%b i=%h p=%h v=%b exp req=0 i=a8 p=8 v=0", i, imem_req, inst_d, pc_d, inst_valid_d);
         end
         if (i < 2) tick();
      end
      stall_f = 1'b0; imem_ready = 1'b0;
      tick();
      tests_run++;
      if (inst_valid_d !== 1'b1 || inst_d !== 32'hAC || pc_d !== 32'hC) begin
         tests_failed++;
         $display("FAIL stall_release got v=%b i=%h p=%h exp v=1 i=ac p=c", inst_valid_d, inst_d, pc_d);
      end
      tick();
      tests_run++;
      if (inst_valid_d !== 1'b0 || pc_f !== 32'h10) begin
         tests_failed++;
         $display("FAIL stall_once got v=%b pc_f=%h exp v=0 pc_f=10", inst_valid_d, pc_f);
      end
   endtask

   // Redirect while waiting; the response two cycles later must be dropped.
   task automatic test_redirect_drop();
      imem_ready = 1'b1; pc_in = 32'h14;
      tick();                       // accept 0x10
      redirect = 1'b1; pc_in = 32'h100;
      settle();
      tests_run++;
      if (imem_req !== 1'b0) begin
         tests_failed++; $display("FAIL drop_noreq got req=%b exp req=0", imem_req);
      end
      tick();
      redirect = 1'b0;
      settle();
      tests_run++;
      if (pc_f !== 32'h100 || imem_req !== 1'b0 || inst_valid_d !== 1'b0) begin
         tests_failed++;
         $display("FAIL drop_wait got pc_f=%h req=%b v=%b exp pc_f=100 req=0 v=0", pc_f, imem_req, inst_valid_d);
      end
      tick();
      imem_rvalid = 1'b1; imem_rdata = 32'hDEAD;
      tick();
      imem_rvalid = 1'b0;
      settle();
      tests_run++;
      if (inst_valid_d !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h100) begin
         tests_failed++;
         $display("FAIL drop_resume got v=%b req=%b addr=%h exp v=0 req=1 addr=100", inst_valid_d, imem_req, imem_addr);
      end
   endtask

   // Redirect and rvalid in the same cycle.
   task automatic test_redirect_same_cycle();
      pc_in = 32'h104;
      tick();                       // accept 0x100
      redirect = 1'b1; pc_in = 32'h100; imem_rvalid = 1'b1; imem_rdata = 32'hBAD;
      tick();
      redirect = 1'b0; imem_rvalid = 1'b0;
      settle();
      tests_run++;
      if (inst_valid_d !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h100) begin
         tests_failed++;
         $display("FAIL same_cycle got v=%b req=%b addr=%h exp v=0 req=1 addr=100", inst_valid_d, imem_req, imem_addr);
      end
   endtask

   // Redirect while a response sits in the hold buffer; buffer is discarded.
   task automatic test_hold_redirect();
      pc_in = 32'h104;
      tick();                       // accept 0x100
      imem_rvalid = 1'b1; imem_rdata = 32'h5555; stall_f = 1'b1;
      tick();                       // held
      imem_rvalid = 1'b0; redirect = 1'b1; pc_in = 32'h200;
      tick();
      redirect = 1'b0; stall_f = 1'b0; imem_ready = 1'b0;
      settle();
      tests_run++;
      if (inst_valid_d !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h200) begin
         tests_failed++;
         $display("FAIL hold_redirect got v=%b req=%b addr=%h exp v=0 req=1 addr=200", inst_valid_d, imem_req, imem_addr);
      end
      tick();
      tests_run++;
      if (inst_valid_d !== 1'b0) begin
         tests_failed++; $display("FAIL hold_discard got v=%b exp v=0", inst_valid_d);
      end
   endtask

   // Reset mid-request; late response after release must be ignored.
   task automatic test_reset_inflight();
      imem_ready = 1'b1; pc_in = 32'h204;
      tick();                       // accept 0x200
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1; imem_ready = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'hBEEF;
      settle();
      tests_run++;
      if (pc_f !== 32'h0 || inst_valid_d !== 1'b0 || inst_d !== 32'h0) begin
         tests_failed++;
         $display("FAIL rst_inflight got pc_f=%h v=%b i=%h exp pc_f=0 v=0 i=0", pc_f, inst_valid_d, inst_d);
      end
      tick();
      imem_rvalid = 1'b0;
      settle();
      tests_run++;
      if (inst_valid_d !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h0) begin
         tests_failed++;
         $display("FAIL rst_late_rvalid got v=%b req=%b addr=%h exp v=0 req=1 addr=0", inst_valid_d, imem_req, imem_addr);
      end
      imem_ready = 1'b1; pc_in = 32'h4;
      tick();
      imem_rvalid = 1'b1; imem_rdata = 32'h11;
      tick();
      imem_rvalid = 1'b0;
      settle();
      tests_run++;
      if (inst_valid_d !== 1'b1 || inst_d !== 32'h11 || pc_d !== 32'h0) begin
         tests_failed++;
         $display("FAIL rst_restart got v=%b i=%h p=%h exp v=1 i=11 p=0", inst_valid_d, inst_d, pc_d);
      end
   endtask

   initial begin
      test_reset();
      test_sequential();
      test_stall();
      test_redirect_drop();
      test_redirect_same_cycle();
      test_hold_redirect();
      test_reset_inflight();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
